// File: rtl/glitch_pkg.sv
// glitch_pkg: shared types and constants for the glitch sequencer.
//   state_t        : sequencer FSM states
//   TRIG_SRC_*     : trigger source encodings for trig_src_i
//   EDGE_*         : trigger edge encodings for trig_edge_i
//   max2()         : elaboration-time helper for sizing the shared counter
package glitch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET,
      ST_WAIT_TRIG,
      ST_DELAY,
      ST_PULSE,
      ST_GAP
   } state_t;

   localparam logic TRIG_SRC_EDGE  = 1'b0;
   localparam logic TRIG_SRC_RESET = 1'b1;
   localparam logic EDGE_RISE      = 1'b1;
   localparam logic EDGE_FALL      = 1'b0;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/trigger_sync.sv
// trigger_sync: synchronises an asynchronous trigger and emits a one-cycle
// detect strobe on the selected edge.
//   clk, rst_n  : clock, asynchronous active-low reset
//   trig_async  : raw external trigger
//   rise_sel    : 1 = rising edge, 0 = falling edge
//   detect      : registered one-cycle edge strobe
// An edge sampled at clock edge n appears on detect in cycle n+SYNC_STAGES.
module trigger_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic trig_async,
   input  logic rise_sel,
   output logic detect
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   edge_seen;

   assign edge_seen = rise_sel ? ( sync_q[SYNC_STAGES-1] & ~prev_q)
                               : (~sync_q[SYNC_STAGES-1] &  prev_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         detect <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], trig_async};
         prev_q <= sync_q[SYNC_STAGES-1];
         // Detect is registered so the strobe is a clean flop output.
         detect <= edge_seen;
      end
   end

endmodule

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: armed, trigger-driven generator of a train of glitch
// pulses with optional target reset beforehand.
//   clk, rst_n        : clock, asynchronous active-low reset
//   arm_i, abort_i    : one-cycle start / abort requests
//   delay_i, width_i, num_pulses_i, spacing_i : pulse train timing (latched at arm)
//   reset_len_i, reset_en_i : target reset length / enable (latched at arm)
//   trig_src_i, trig_edge_i : trigger source / edge select (latched at arm)
//   trigger_i         : asynchronous external trigger
//   pulse_o, target_reset_o : registered glitch and target-reset outputs
//   busy_o, armed_o, done_o : status (non-idle, waiting trigger, completion strobe)
module glitch_sequencer
   import glitch_pkg::*;
#(
   parameter int DELAY_W     = 24,
   parameter int WIDTH_W     = 16,
   parameter int COUNT_W     = 8,
   parameter int SPACING_W   = 24,
   parameter int RESET_W     = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 arm_i,
   input  logic                 abort_i,
   input  logic [DELAY_W-1:0]   delay_i,
   input  logic [WIDTH_W-1:0]   width_i,
   input  logic [COUNT_W-1:0]   num_pulses_i,
   input  logic [SPACING_W-1:0] spacing_i,
   input  logic [RESET_W-1:0]   reset_len_i,
   input  logic                 reset_en_i,
   input  logic                 trig_src_i,
   input  logic                 trig_edge_i,
   input  logic                 trigger_i,
   output logic                 pulse_o,
   output logic                 target_reset_o,
   output logic                 busy_o,
   output logic                 armed_o,
   output logic                 done_o
);

   // One down-counter serves every timed phase, so it is as wide as the widest.
   localparam int CNT_W = max2(max2(DELAY_W, WIDTH_W), max2(SPACING_W, RESET_W));

   state_t                 state_q, state_n;
   logic [CNT_W-1:0]       cnt_q, cnt_n;
   logic [COUNT_W-1:0]     pcnt_q, pcnt_n;
   logic                   done_n;
   logic                   latch;

   logic [DELAY_W-1:0]     delay_q;
   logic [WIDTH_W-1:0]     width_q;
   logic [SPACING_W-1:0]   spacing_q;
   logic                   src_q;
   logic                   edge_q;
   logic                   detect;

   // Outcome of starting the pulse train now (pul_*) and of leaving the
   // trigger-detect point (seq_*), which first passes through DELAY if needed.
   state_t                 pul_state, seq_state;
   logic [CNT_W-1:0]       pul_cnt, seq_cnt;
   logic                   pul_done, seq_done;

   trigger_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .trig_async (trigger_i),
      .rise_sel   (edge_q == EDGE_RISE),
      .detect     (detect)
   );

   assign latch   = (state_q == ST_IDLE) && arm_i;
   assign busy_o  = (state_q != ST_IDLE);
   assign armed_o = (state_q == ST_WAIT_TRIG);

   always_comb begin
      pul_state = ST_PULSE;
      pul_cnt   = CNT_W'(width_q) - CNT_W'(1);
      pul_done  = 1'b0;
      if (width_q == '0 || pcnt_q == '0) begin
         pul_state = ST_IDLE;
         pul_cnt   = '0;
         pul_done  = 1'b1;
      end
      seq_state = pul_state;
      seq_cnt   = pul_cnt;
      seq_done  = pul_done;
      if (delay_q != '0) begin
         seq_state = ST_DELAY;
         seq_cnt   = CNT_W'(delay_q) - CNT_W'(1);
         seq_done  = 1'b0;
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      pcnt_n  = pcnt_q;
      done_n  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arm_i) begin
               pcnt_n = num_pulses_i;
               if (reset_en_i) begin
                  state_n = ST_RESET;
                  // reset_len of 0 still gives one reset cycle.
                  cnt_n   = (reset_len_i == '0) ? '0 : CNT_W'(reset_len_i) - CNT_W'(1);
               end else begin
                  state_n = ST_WAIT_TRIG;
               end
            end
         end
         ST_RESET: begin
            if (cnt_q == '0) begin
               if (src_q == TRIG_SRC_RESET) begin
                  // Reset release is itself the trigger: last reset cycle is D.
                  state_n = seq_state;
                  cnt_n   = seq_cnt;
                  done_n  = seq_done;
               end else begin
                  state_n = ST_WAIT_TRIG;
               end
            end else begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end
         ST_WAIT_TRIG: begin
            if (detect) begin
               state_n = seq_state;
               cnt_n   = seq_cnt;
               done_n  = seq_done;
            end
         end
         ST_DELAY: begin
            if (cnt_q == '0) begin
               state_n = pul_state;
               cnt_n   = pul_cnt;
               done_n  = pul_done;
            end else begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               if (pcnt_q <= COUNT_W'(1)) begin
                  state_n = ST_IDLE;
                  done_n  = 1'b1;
               end else begin
                  pcnt_n = pcnt_q - COUNT_W'(1);
                  if (spacing_q == '0) begin
                     // Zero gap: next pulse follows back-to-back, output stays high.
                     state_n = ST_PULSE;
                     cnt_n   = CNT_W'(width_q) - CNT_W'(1);
                  end else begin
                     state_n = ST_GAP;
                     cnt_n   = CNT_W'(spacing_q) - CNT_W'(1);
                  end
               end
            end else begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_n = ST_PULSE;
               cnt_n   = CNT_W'(width_q) - CNT_W'(1);
            end else begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
      // Abort overrides every other event outside IDLE.
      if (abort_i && state_q != ST_IDLE) begin
         state_n = ST_IDLE;
         done_n  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         pcnt_q         <= '0;
         pulse_o        <= 1'b0;
         target_reset_o <= 1'b0;
         done_o         <= 1'b0;
      end else begin
         state_q        <= state_n;
         cnt_q          <= cnt_n;
         pcnt_q         <= pcnt_n;
         // Outputs follow the state being entered so they line up with it.
         pulse_o        <= (state_n == ST_PULSE);
         target_reset_o <= (state_n == ST_RESET);
         done_o         <= done_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         delay_q   <= '0;
         width_q   <= '0;
         spacing_q <= '0;
         src_q     <= TRIG_SRC_EDGE;
         edge_q    <= EDGE_FALL;
      end else if (latch) begin
         delay_q   <= delay_i;
         width_q   <= width_i;
         spacing_q <= spacing_i;
         // Release-triggering needs a reset phase; without one fall back to the edge.
         src_q     <= reset_en_i ? trig_src_i : TRIG_SRC_EDGE;
         edge_q    <= trig_edge_i;
      end
   end

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb_glitch_sequencer: directed bench for glitch_sequencer.
// Observed vector per check is {pulse_o, target_reset_o, busy_o, armed_o, done_o}.
module tb_glitch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        arm_i, abort_i;
   logic [23:0] delay_i;
   logic [15:0] width_i;
   logic [7:0]  num_pulses_i;
   logic [23:0] spacing_i;
   logic [15:0] reset_len_i;
   logic        reset_en_i, trig_src_i, trig_edge_i, trigger_i;
   logic        pulse_o, target_reset_o, busy_o, armed_o, done_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   glitch_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .arm_i          (arm_i),
      .abort_i        (abort_i),
      .delay_i        (delay_i),
      .width_i        (width_i),
      .num_pulses_i   (num_pulses_i),
      .spacing_i      (spacing_i),
      .reset_len_i    (reset_len_i),
      .reset_en_i     (reset_en_i),
      .trig_src_i     (trig_src_i),
      .trig_edge_i    (trig_edge_i),
      .trigger_i      (trigger_i),
      .pulse_o        (pulse_o),
      .target_reset_o (target_reset_o),
      .busy_o         (busy_o),
      .armed_o        (armed_o),
      .done_o         (done_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [4:0] exp);
      logic [4:0] obs;
      obs = {pulse_o, target_reset_o, busy_o, armed_o, done_o};
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic expect_n(input string tag, input int n, input logic [4:0] exp);
      for (int i = 0; i < n; i++) begin
         tick();
         chk(tag, exp);
      end
   endtask

   task automatic setcfg(input int d, input int w, input int n, input int s,
                         input int rl, input logic ren, input logic src, input logic edg);
      delay_i      = 24'(d);
      width_i      = 16'(w);
      num_pulses_i = 8'(n);
      spacing_i    = 24'(s);
      reset_len_i  = 16'(rl);
      reset_en_i   = ren;
      trig_src_i   = src;
      trig_edge_i  = edg;
   endtask

   // Arm in the current cycle A; returns in cycle A+1.
   task automatic arm();
      arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
   endtask

   // Bring the trigger low while idle; the resulting detect lands in IDLE.
   task automatic trig_low_settle();
      trigger_i = 1'b0;
      expect_n("settle_idle", 5, 5'b00000);
   endtask

   initial begin
      rst_n = 1'b0; arm_i = 1'b0; abort_i = 1'b0; trigger_i = 1'b0;
      setcfg(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
      tick(); tick();
      chk("reset_state", 5'b00000);
      rst_n = 1'b1;
      expect_n("idle_after_reset", 2, 5'b00000);

      // Basic rising-edge trigger: D=A+4, pulses A+8..9 and A+11..12, done A+13.
      setcfg(3, 2, 2, 1, 0, 1'b0, 1'b0, 1'b1);
      arm();
      chk("t1_armed", 5'b00110);
      setcfg(9, 9, 9, 9, 0, 1'b0, 1'b0, 1'b1);   // post-arm changes must not matter
      trigger_i = 1'b1;
      expect_n("t1_wait", 3, 5'b00110);
      expect_n("t1_delay", 3, 5'b00100);
      expect_n("t1_pulse0", 2, 5'b10100);
      expect_n("t1_gap", 1, 5'b00100);
      expect_n("t1_pulse1", 2, 5'b10100);
      expect_n("t1_done", 1, 5'b00001);
      expect_n("t1_idle", 1, 5'b00000);

      // Target reset with release trigger: reset A+1..A+5, pulse A+6, done A+7.
      trigger_i = 1'b0;
      setcfg(0, 1, 1, 0, 5, 1'b1, 1'b1, 1'b1);
      arm();
      chk("t2_reset_first", 5'b01100);
      expect_n("t2_reset", 4, 5'b01100);
      expect_n("t2_pulse", 1, 5'b10100);
      expect_n("t2_done", 1, 5'b00001);
      expect_n("t2_idle", 1, 5'b00000);

      // Falling-edge select: rising edge ignored, falling edge pulses n+3.
      setcfg(0, 1, 1, 0, 0, 1'b0, 1'b0, 1'b0);
      arm();
      chk("t3_armed", 5'b00110);
      trigger_i = 1'b1;
      expect_n("t3_rise_ignored", 5, 5'b00110);
      trigger_i = 1'b0;
      expect_n("t3_wait_fall", 3, 5'b00110);
      expect_n("t3_pulse", 1, 5'b10100);
      expect_n("t3_done", 1, 5'b00001);

      // Abort in mid-pulse, then a fresh complete sequence.
      setcfg(0, 3, 4, 2, 0, 1'b0, 1'b0, 1'b1);
      arm();
      chk("t4_armed", 5'b00110);
      trigger_i = 1'b1;
      expect_n("t4_wait", 3, 5'b00110);
      expect_n("t4_pulse", 2, 5'b10100);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("t4_aborted", 5'b00000);
      trig_low_settle();
      setcfg(1, 1, 1, 0, 0, 1'b0, 1'b0, 1'b1);
      arm();
      chk("t4b_armed", 5'b00110);
      trigger_i = 1'b1;
      expect_n("t4b_wait", 3, 5'b00110);
      expect_n("t4b_delay", 1, 5'b00100);
      expect_n("t4b_pulse", 1, 5'b10100);
      expect_n("t4b_done", 1, 5'b00001);

      // num=0 with delay=2: done at D+3.
      trig_low_settle();
      setcfg(2, 2, 0, 1, 0, 1'b0, 1'b0, 1'b1);
      arm();
      trigger_i = 1'b1;
      expect_n("t5a_wait", 3, 5'b00110);
      expect_n("t5a_delay", 2, 5'b00100);
      expect_n("t5a_done", 1, 5'b00001);

      // width=0, delay=0: done at D+1.
      trig_low_settle();
      setcfg(0, 0, 2, 1, 0, 1'b0, 1'b0, 1'b1);
      arm();
      trigger_i = 1'b1;
      expect_n("t5b_wait", 3, 5'b00110);
      expect_n("t5b_done", 1, 5'b00001);

      // spacing=0: three width-2 pulses merge into six high cycles.
      trig_low_settle();
      setcfg(0, 2, 3, 0, 0, 1'b0, 1'b0, 1'b1);
      arm();
      trigger_i = 1'b1;
      expect_n("t5c_wait", 3, 5'b00110);
      expect_n("t5c_merged", 6, 5'b10100);
      expect_n("t5c_done", 1, 5'b00001);

      // arm during DELAY and a trigger edge during GAP change nothing.
      trig_low_settle();
      setcfg(4, 1, 2, 2, 0, 1'b0, 1'b0, 1'b1);
      arm();
      trigger_i = 1'b1;
      expect_n("t6_wait", 3, 5'b00110);
      expect_n("t6_delay", 1, 5'b00100);
      setcfg(0, 5, 1, 0, 0, 1'b1, 1'b0, 1'b1);
      arm_i = 1'b1;
      tick();
      arm_i = 1'b0;
      chk("t6_arm_ignored", 5'b00100);
      trigger_i = 1'b0;
      expect_n("t6_delay_rest", 2, 5'b00100);
      trigger_i = 1'b1;
      expect_n("t6_pulse0", 1, 5'b10100);
      expect_n("t6_gap", 2, 5'b00100);
      expect_n("t6_pulse1", 1, 5'b10100);
      expect_n("t6_done", 1, 5'b00001);

      // Async reset during PULSE clears outputs at once.
      trig_low_settle();
      setcfg(0, 4, 1, 0, 0, 1'b0, 1'b0, 1'b1);
      arm();
      trigger_i = 1'b1;
      expect_n("t7_wait", 3, 5'b00110);
      expect_n("t7_pulse", 1, 5'b10100);
      rst_n = 1'b0;
      #1;
      chk("t7_async_reset", 5'b00000);
      tick();
      chk("t7_held_reset", 5'b00000);
      rst_n = 1'b1;
      expect_n("t7_idle", 3, 5'b00000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
Parametrised successor to the single-shot pulser path of the glitch controller. Adds target-reset generation, a real trigger input (synchronised, selectable edge or reset-release source), arm/abort control and a done strobe. Generic counter widths allow long delays at high clock rates. Sits between the UART config registers and the glitch output pins; all config arrives as static register values latched at arm time.

Parameters:
DELAY_W, 24, width of delay_i (trigger-to-first-pulse cycles)
WIDTH_W, 16, width of width_i (pulse high cycles)
COUNT_W, 8, width of num_pulses_i
SPACING_W, 24, width of spacing_i (low cycles between pulses)
RESET_W, 16, width of reset_len_i (target reset cycles)
SYNC_STAGES, 2, trigger synchroniser depth (>=2)

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
arm_i  in  1  one-cycle start request
abort_i  in  1  one-cycle abort request
delay_i  in  DELAY_W  cycles from trigger detect to first pulse
width_i  in  WIDTH_W  pulse high length
num_pulses_i  in  COUNT_W  pulses per trigger
spacing_i  in  SPACING_W  low gap between pulses
reset_len_i  in  RESET_W  target reset length
reset_en_i  in  1  issue target reset before waiting for trigger
trig_src_i  in  1  0 = trigger_i edge, 1 = target-reset release
trig_edge_i  in  1  1 = rising, 0 = falling edge of trigger_i
trigger_i  in  1  asynchronous external trigger
pulse_o  out  1  glitch pulse, registered
target_reset_o  out  1  target reset, active high, registered
busy_o  out  1  high in any state except IDLE
armed_o  out  1  high in WAIT_TRIG
done_o  out  1  one-cycle strobe after last pulse

Behaviour:
- Reset: all outputs 0, FSM IDLE, sync regs 0, counters 0.
- States: IDLE, RESET, WAIT_TRIG, DELAY, PULSE, GAP.
- IDLE: arm_i in cycle A latches all cfg inputs. At A+1: RESET if reset_en_i, else WAIT_TRIG. busy_o high from A+1. arm_i outside IDLE is ignored. Cfg changes after A have no effect.
- RESET: target_reset_o high for exactly max(reset_len,1) cycles from A+1. Last reset cycle = R. Then:
  - trig_src=1: detect cycle D = R, DELAY from R+1.
  - trig_src=0: WAIT_TRIG from R+1.
- trig_src=1 with reset_en=0: treated as trig_src=0.
- Trigger path: SYNC_STAGES flop chain plus one previous-value flop. An edge of trigger_i sampled at clock edge n asserts detect in cycle n+SYNC_STAGES.
- Detect is evaluated only in WAIT_TRIG; edges in any other state are discarded (no queueing). Detect cycle = D; DELAY from D+1.
- Timing for pulse k (0-based): pulse_o high over cycles D+1+delay+k*(width+spacing) through D+delay+width+k*(width+spacing).
- delay=0: first pulse at D+1.
- spacing=0: consecutive pulses merge, so pulse_o stays high continuously.
- width=0 or num_pulses=0: no pulse is generated; done_o fires at D+1+delay.
- Completion: last pulse high cycle L. At L+1: done_o=1 for one cycle, FSM back in IDLE, busy_o=0. arm_i accepted again from L+1.
- abort_i in any non-IDLE state wins over every other event in that cycle. At the next cycle: IDLE, pulse_o=0, target_reset_o=0, no done_o. abort_i in IDLE has no effect.
- arm_i and abort_i together in IDLE: arm wins.
- Async rst_n assertion mid-operation drops pulse_o and target_reset_o immediately.
- Counters count down from the latched value. No wrap: maximum values give the full 2^W-1 cycles.

Decomposition:
- glitch_pkg: FSM state enum; TRIG_SRC_EDGE/TRIG_SRC_RESET and EDGE_RISE/EDGE_FALL constants.
- Sub-module trigger_sync (SYNC_STAGES parameter; edge select input; one-cycle detect output). All remaining logic lives in glitch_sequencer.

Test Plan:
- Basic edge trigger. Config: delay=3, width=2, num=2, spacing=1, rising, no reset. Rising trigger sampled at n (D=n+2) -> pulse_o high D+4..D+5 and D+7..D+8; done_o at D+9; busy_o low at D+9.
- Target reset + release trigger. Config: reset_en=1, reset_len=5, trig_src=1, delay=0, width=1, num=1. arm at A -> target_reset_o high A+1..A+5; pulse_o high A+6 only; done_o at A+7.
- Falling-edge select. Config: trig_edge=0, delay=0, width=1, num=1. Rising edge while armed -> no pulse, armed_o stays 1. Following falling edge -> pulse 3 cycles after it is sampled (SYNC_STAGES=2).
- Abort. Abort in the middle of PULSE with num=4 -> pulse_o 0 next cycle, no done_o, busy_o 0. A new arm then completes a full sequence.
- Degenerate configs. num=0 -> no pulse, done_o at D+1+delay. width=0 -> same. spacing=0, width=2, num=3 -> pulse_o high for 6 contiguous cycles.
- Ignored events. arm_i pulsed during DELAY -> no effect. Trigger edge during GAP -> no restart, timing unchanged. rst_n asserted during PULSE -> pulse_o 0 immediately, FSM IDLE.
